alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one N-bit `alu` between two requesters using a valid/ready request channel and a single tagged response channel. Each transaction is sequenced through grant, execute and respond. A request accepted in cycle T returns a registered result and flags no earlier than T+2. The block sits between the two issuing units (e.g. code-converter front ends) and the shared ALU datapath.

## Interface
- `N`, 4: operand/result width (≥2)
- `clk` input 1: clock, rising edge
- `rst` input 1: reset, synchronous, active-high
- `req_valid` input 2: bit i = requester i presents an operation
- `req_ready` output 2: bit i = requester i's operation accepted this cycle (one-hot or zero)
- `req_a` input 2N: operand a; requester i in bits [i*N +: N]
- `req_b` input 2N: operand b, same packing
- `req_op` input 6: opcode; requester i in bits [i*3 +: 3]
- `rsp_valid` output 1: response present
- `rsp_ready` input 1: consumer takes response
- `rsp_id` output 1: requester that owns the response
- `rsp_result` output N: ALU result
- `rsp_zero`, `rsp_carry`, `rsp_overflow` output 1 each: ALU flags
- `busy` output 1: state ≠ IDLE

## Operation
- Opcodes:
  - 000 ADD: carry = carry-out; overflow = signed overflow.
  - 001 SUB, a−b: carry = borrow; overflow = signed overflow.
  - 010 AND, 011 OR, 100 XOR.
  - 101 NOT a, 110 a<<1, 111 a>>1 (logical): b ignored.
  - zero = (result==0) for every op. carry and overflow = 0 for ops 010–111.
- FSM IDLE → EXEC → RESP → IDLE.
- IDLE:
  - If any `req_valid`, grant one requester: `req_ready` bit set combinationally that cycle.
  - Latch a, b, op and id.
  - Round-robin pointer moves to the non-granted requester. Go to EXEC.
- EXEC: the ALU sees the latched operands; result and flags are registered into `rsp_*`. Go to RESP.
- RESP:
  - `rsp_valid`=1.
  - All `rsp_*` outputs stay stable until `rsp_valid && rsp_ready`, then return to IDLE.
  - No grant is issued outside IDLE.
- Arbitration:
  - Only one valid: it wins regardless of pointer.
  - Both valid: the pointer wins. Pointer resets to 0.
- Requester protocol: once `req_valid[i]` is raised, a, b and op are held until `req_ready[i]`. The block need not tolerate violations.

## Timing
- Reset values:
  - `req_ready`=00, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, all flags 0, `busy`=0.
  - state IDLE, pointer 0.
- Latency: grant at T, `rsp_valid` at T+2. If `rsp_ready` is high at T+2, IDLE at T+3 and the next grant no earlier than T+3. Peak throughput is 1 op per 3 cycles.
- `req_ready` depends only on state, pointer and `req_valid`. There is no combinational path from `rsp_ready`.
- `rst` in any state, including mid-EXEC or RESP:
  - Next cycle matches the reset values.
  - The in-flight operation is dropped and never responded.
- `rsp_ready` high while `rsp_valid` is low is ignored.

## Structure
- Package `alu_pkg`:
  - opcode localparams `OP_ADD` … `OP_RSH`
  - `ALU_OP_W`=3
  - state typedef `arb_state_t` {IDLE, EXEC, RESP}
- One sub-module: the existing `alu` (parameter N), instantiated once and fed from the latched operand registers.
- Arbiter, FSM and response registers live in `alu_arbiter`.

## Test plan
- Reset: hold `rst` 2 cycles with `req_valid`=11. Then `req_ready`=00, `rsp_valid`=0, `rsp_result`=0000, `busy`=0.
- Single request: req0 ADD 0010+0011 at T. Expect `req_ready`=01 at T, and at T+2 `rsp_valid`=1, id 0, result 0101, zero/carry/overflow 0/0/0.
- Contention after reset: req0 SUB 0101−0011 and req1 AND 1010&1100 both valid.
  - req0 is served first: result 0010.
  - req1 is granted at the next IDLE: id 1, result 1000.
  - A third simultaneous pair goes to req0.
- Backpressure: req1 ADD 1000+1000 with `rsp_ready`=0 for 5 cycles.
  - Result 0000, zero 1, carry 1, overflow 1, held stable the whole time.
  - A pending req0 gets no `req_ready` until one cycle after the handshake.
- Flag/shift checks:
  - SUB 0001−0010 gives 1111, carry 1, overflow 0.
  - RSH 1011 (b=xxxx) gives 0101, carry 0.
  - LSH 1011 gives 0110.
  - NOT 1010 gives 0101.
- Reset mid-operation: assert `rst` for one cycle while in EXEC. Next cycle `rsp_valid`=0 and `busy`=0, the dropped op never appears, and a fresh req0 is then granted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: opcode encodings and FSM state type.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [ALU_OP_W-1:0] OP_NOT = 3'd5;
    localparam logic [ALU_OP_W-1:0] OP_LSH = 3'd6;
    localparam logic [ALU_OP_W-1:0] OP_RSH = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: arithmetic with carry/borrow and signed overflow, logic ops, 1-bit shifts.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]        i_a,
    input  logic [N-1:0]        i_b,
    input  logic [ALU_OP_W-1:0] i_op,
    output logic [N-1:0]        o_result_c,
    output logic                o_zero_c,
    output logic                o_carry_c,
    output logic                o_overflow_c
);

    logic [N:0] w_sum;
    logic [N:0] w_diff;

    // Extra MSB captures carry-out on add and borrow on subtract.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result_c   = '0;
        o_carry_c    = 1'b0;
        o_overflow_c = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result_c   = w_sum[N-1:0];
                o_carry_c    = w_sum[N];
                o_overflow_c = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
            end
            OP_SUB: begin
                o_result_c   = w_diff[N-1:0];
                o_carry_c    = w_diff[N];
                o_overflow_c = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
            end
            OP_AND:  o_result_c = i_a & i_b;
            OP_OR:   o_result_c = i_a | i_b;
            OP_XOR:  o_result_c = i_a ^ i_b;
            OP_NOT:  o_result_c = ~i_a;
            OP_LSH:  o_result_c = {i_a[N-2:0], 1'b0};
            OP_RSH:  o_result_c = {1'b0, i_a[N-1:1]};
            default: o_result_c = '0;
        endcase
    end

    assign o_zero_c = (o_result_c == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; each op runs grant -> execute -> respond.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*N-1:0]        req_a,
    input  logic [2*N-1:0]        req_b,
    input  logic [2*ALU_OP_W-1:0] req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [N-1:0]          rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_carry,
    output logic                  rsp_overflow,
    output logic                  busy
);

    arb_state_t          r_state;
    logic                r_ptr;
    logic [N-1:0]        r_a;
    logic [N-1:0]        r_b;
    logic [ALU_OP_W-1:0] r_op;
    logic                r_id;

    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [N-1:0]        r_rsp_result;
    logic                r_rsp_zero;
    logic                r_rsp_carry;
    logic                r_rsp_overflow;

    logic                w_any;
    logic                w_gid;
    logic [1:0]          w_ready;
    logic [N-1:0]        w_result;
    logic                w_zero;
    logic                w_carry;
    logic                w_overflow;

    // Sole requester wins outright; on contention the round-robin pointer decides.
    assign w_any = |req_valid;
    assign w_gid = (&req_valid) ? r_ptr : req_valid[1];

    // No grant while reset is asserted: the op would be dropped by the reset edge anyway.
    always_comb begin
        w_ready = 2'b00;
        if ((r_state == IDLE) && w_any && !rst) begin
            w_ready = w_gid ? 2'b10 : 2'b01;
        end
    end

    assign req_ready = w_ready;

    alu #(
        .N(N)
    ) u_alu (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_op        (r_op),
        .o_result_c  (w_result),
        .o_zero_c    (w_zero),
        .o_carry_c   (w_carry),
        .o_overflow_c(w_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ptr          <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= OP_ADD;
            r_id           <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= w_gid ? req_a[2*N-1:N] : req_a[N-1:0];
                        r_b     <= w_gid ? req_b[2*N-1:N] : req_b[N-1:0];
                        r_op    <= w_gid ? req_op[2*ALU_OP_W-1:ALU_OP_W] : req_op[ALU_OP_W-1:0];
                        r_id    <= w_gid;
                        r_ptr   <= ~w_gid;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_valid    <= 1'b1;
                    r_rsp_id       <= r_id;
                    r_rsp_result   <= w_result;
                    r_rsp_zero     <= w_zero;
                    r_rsp_carry    <= w_carry;
                    r_rsp_overflow <= w_overflow;
                    r_state        <= RESP;
                end
                RESP: begin
                    // Response registers hold until the consumer takes it.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_overflow = r_rsp_overflow;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = N + 4;
    localparam int M = 1 << N;
    localparam int H = 1 << (N - 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [2*N-1:0]        req_a;
    logic [2*N-1:0]        req_b;
    logic [2*ALU_OP_W-1:0] req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [N-1:0]          rsp_result;
    logic                  rsp_zero;
    logic                  rsp_carry;
    logic                  rsp_overflow;
    logic                  busy;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_carry   (rsp_carry),
        .rsp_overflow(rsp_overflow),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side sources (held until granted) and the transaction model.
    bit             src_v  [2];
    logic [N-1:0]   src_a  [2];
    logic [N-1:0]   src_b  [2];
    logic [2:0]     src_op [2];
    bit             m_idle = 1'b1;
    int             m_cnt  = 0;
    bit             m_ptr  = 1'b0;
    logic [PW-1:0]  m_exp  = '0;
    logic [PW-1:0]  log_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected response {id, result, zero, carry, overflow} from plain integer arithmetic.
    function automatic logic [PW-1:0] ref_rsp(input bit id, input logic [2:0] op,
                                              input logic [N-1:0] a, input logic [N-1:0] b);
        int ua, ub, sa, sb, r, s;
        bit c, v;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= H) ? ua - M : ua;
        sb = (ub >= H) ? ub - M : ub;
        c = 1'b0;
        v = 1'b0;
        s = 0;
        case (op)
            3'd0: begin r = ua + ub;     c = (r >= M);  s = sa + sb; v = (s >= H) || (s < -H); end
            3'd1: begin r = ua - ub + M; c = (ua < ub); s = sa - sb; v = (s >= H) || (s < -H); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = M - 1 - ua;
            3'd6: r = ua * 2;
            default: r = ua / 2;
        endcase
        r = r % M;
        return {id, N'(r), (r == 0), c, v};
    endfunction

    task automatic apply();
        req_valid = {src_v[1], src_v[0]};
        req_a     = {src_a[1], src_a[0]};
        req_b     = {src_b[1], src_b[0]};
        req_op    = {src_op[1], src_op[0]};
    endtask

    task automatic set_src(input int i, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        src_v[i]  = 1'b1;
        src_op[i] = op;
        src_a[i]  = a;
        src_b[i]  = b;
    endtask

    // One cycle: drive at negedge, check 1ns later, then advance the model across the posedge.
    task automatic step();
        logic [1:0]    exp_ready;
        bit            exp_valid;
        bit            g;
        logic [PW-1:0] obs;
        apply();
        #1;
        g = 1'b0;
        exp_ready = 2'b00;
        if (!rst && m_idle && (src_v[0] || src_v[1])) begin
            g = (src_v[0] && src_v[1]) ? m_ptr : src_v[1];
            exp_ready = g ? 2'b10 : 2'b01;
        end
        exp_valid = !m_idle && (m_cnt >= 2);
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        check_eq("busy", 32'(busy), 32'(!m_idle));
        obs = {rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow};
        if (exp_valid) check_eq("rsp_payload", 32'(obs), 32'(m_exp));
        if (rsp_valid && rsp_ready && !rst) log_q.push_back(obs);
        if (rst) begin
            m_idle = 1'b1;
            m_ptr  = 1'b0;
            m_cnt  = 0;
        end else if (exp_ready != 2'b00) begin
            m_exp    = ref_rsp(g, src_op[g], src_a[g], src_b[g]);
            m_ptr    = !g;
            m_idle   = 1'b0;
            m_cnt    = 1;
            src_v[g] = 1'b0;
        end else if (!m_idle) begin
            if (exp_valid && rsp_ready) m_idle = 1'b1;
            else m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_log(input string tag, input int idx, input logic [PW-1:0] exp);
        logic [31:0] v;
        v = '1;
        if (idx < log_q.size()) v = 32'(log_q[idx]);
        check_eq(tag, v, 32'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) set_src(i, OP_ADD, N'(i + 1), N'(i + 2));
        apply();
        @(negedge clk);
        // Second reset cycle with both requesters valid: outputs at reset values.
        apply();
        #1;
        check_eq("rst_payload", 32'({rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow}), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        src_v[0] = 1'b0;
        src_v[1] = 1'b0;

        set_src(0, OP_ADD, 4'b0010, 4'b0011);
        run(4);
        check_log("single_add", 0, 8'b0_0101_000);

        rst = 1'b1;
        step();
        rst = 1'b0;

        set_src(0, OP_SUB, 4'b0101, 4'b0011);
        set_src(1, OP_AND, 4'b1010, 4'b1100);
        run(7);
        check_log("contend_req0", 1, 8'b0_0010_000);
        check_log("contend_req1", 2, 8'b1_1000_000);
        set_src(0, OP_XOR, 4'b0110, 4'b0110);
        set_src(1, OP_OR,  4'b0001, 4'b0010);
        run(7);
        check_log("third_pair_req0", 3, 8'b0_0000_100);
        check_log("third_pair_req1", 4, 8'b1_0011_000);

        rsp_ready = 1'b0;
        set_src(1, OP_ADD, 4'b1000, 4'b1000);
        step();
        set_src(0, OP_ADD, 4'b0001, 4'b0001);
        run(6);
        rsp_ready = 1'b1;
        run(5);
        check_log("backpressure", 5, 8'b1_0000_111);
        check_log("after_bp_req0", 6, 8'b0_0010_000);

        set_src(0, OP_SUB, 4'b0001, 4'b0010);
        run(4);
        set_src(0, OP_RSH, 4'b1011, N'($urandom));
        run(4);
        set_src(0, OP_LSH, 4'b1011, N'($urandom));
        run(4);
        set_src(0, OP_NOT, 4'b1010, 4'b0000);
        run(4);
        check_log("sub_borrow", 7, 8'b0_1111_010);
        check_log("rsh", 8, 8'b0_0101_000);
        check_log("lsh", 9, 8'b0_0110_000);
        check_log("not", 10, 8'b0_0101_000);

        set_src(0, OP_ADD, 4'b0001, 4'b0001);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        apply();
        #1;
        check_eq("midrst_valid", 32'(rsp_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        run(4);
        check_eq("midrst_dropped", 32'(log_q.size()), 32'd11);
        set_src(0, OP_ADD, 4'b0011, 4'b0100);
        run(4);
        check_log("after_midrst", 11, 8'b0_0111_000);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!src_v[i] && ($urandom_range(0, 2) == 0))
                    set_src(i, 3'($urandom), N'($urandom), N'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
